drum_step_sequencer: RTL and testbench

// - 16-step, 4-voice drum pattern sequencer. Drives the shared sample player: kick/snare/hat/clap ROMs behind one address counter.
// - Holds the pattern, generates step ticks from a tempo divider, and schedules the voices due on each step onto the single player.
// - Scheduling uses fixed priority.
// - Outputs go/en/sel straight into the sample player; play_done comes back from its address counter.

---
 rtl/drum_step_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_drum_step_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/drum_step_sequencer.sv
// drum_step_sequencer
//   A 16-step drum pattern sequencer with four voices. It sends voice hits
//   one at a time to a single shared sample player. The player is one address
//   counter in front of the kick/snare/hat/clap ROMs.
//
//   A tempo divider produces step ticks. On each tick the pattern column for
//   the new step is loaded into a pending mask. A fixed-priority scheduler then
//   launches the pending voices one after another. Kick has the highest
//   priority and clap the lowest.
//
// Optional feature (macro DROP_COUNT_EN):
//   When the macro is defined, the module has an extra output drop_cnt[7:0].
//   It is a saturating count of hits that were discarded. A hit is discarded
//   when pending is replaced, or when a playing voice is preempted.
//
// Ports
//   clk        in   1       system clock, posedge
//   reset      in   1       synchronous active-high reset
//   run        in   1       1 = running, 0 = stopped
//   tempo_div  in   DIV_W   step period = max(tempo_div, MIN_DIV) + 1 cycles
//   pat_we     in   1       pattern write strobe
//   pat_voice  in   2       voice to write (0 kick, 1 snare, 2 hat, 3 clap)
//   pat_step   in   STEP_W  step index to write
//   pat_bit    in   1       hit value written
//   play_done  in   1       player finished the current sample (1-cycle pulse)
//   go         out  1       1-cycle pulse that restarts the player address
//   en         out  1       player count enable
//   sel        out  2       voice select to the player mux
//   step       out  STEP_W  current step index
//   tick       out  1       1-cycle pulse on each step
//   drop_cnt   out  8       discarded-hit count (DROP_COUNT_EN only)
module drum_step_sequencer #(
    parameter int STEPS   = 16,
    parameter int DIV_W   = 16,
    parameter int MIN_DIV = 3,
    localparam int STEP_W = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [DIV_W-1:0]  tempo_div,
    input  logic              pat_we,
    input  logic [1:0]        pat_voice,
    input  logic [STEP_W-1:0] pat_step,
    input  logic              pat_bit,
    input  logic              play_done,
    output logic              go,
    output logic              en,
    output logic [1:0]        sel,
    output logic [STEP_W-1:0] step,
    output logic              tick
`ifdef DROP_COUNT_EN
    ,
    output logic [7:0]        drop_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        PLAY   = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [STEPS-1:0]   pattern [4];
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   eff_div;
    logic               run_q;
    logic               start;
    logic [STEP_W-1:0]  next_step;
    logic [3:0]         capture;
    logic [3:0]         pending, pending_nx;
    logic [1:0]         sel_nx;

    // Tempo divider and tick generation.
    assign eff_div   = (tempo_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : tempo_div;
    assign start     = run & ~run_q;
    assign tick      = run & (start | (div_cnt == eff_div));
    // A start tick restarts the bar at step 0. Every other tick advances the step.
    assign next_step = start ? '0 : step + STEP_W'(1);

    // Column of the pattern at the step being entered. Reads the registered
    // pattern, so a write in the same cycle lands after the capture.
    always_comb begin
        for (int unsigned v = 0; v < 4; v++) begin
            capture[v] = pattern[v][next_step];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run_q   <= 1'b0;
            div_cnt <= '0;
            step    <= '0;
        end else begin
            run_q <= run;
            if (!run || tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
            if (tick) begin
                step <= next_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned v = 0; v < 4; v++) begin
                pattern[v] <= '0;
            end
        end else if (pat_we) begin
            pattern[pat_voice][pat_step] <= pat_bit;
        end
    end

    // Scheduler: state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
            sel     <= '0;
        end else begin
            state   <= state_nx;
            pending <= pending_nx;
            sel     <= sel_nx;
        end
    end

    // Scheduler: next state. A stop or a tick overrides any state. A tick
    // replaces the pending mask and abandons a voice that is launching or playing.
    always_comb begin
        state_nx   = state;
        pending_nx = pending;
        sel_nx     = sel;
        if (!run) begin
            state_nx   = IDLE;
            pending_nx = '0;
        end else if (tick) begin
            state_nx   = IDLE;
            pending_nx = capture;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pending != '0) begin
                        state_nx = LAUNCH;
                        if (pending[0])      sel_nx = 2'd0;
                        else if (pending[1]) sel_nx = 2'd1;
                        else if (pending[2]) sel_nx = 2'd2;
                        else                 sel_nx = 2'd3;
                    end
                end
                LAUNCH: begin
                    pending_nx[sel] = 1'b0;
                    state_nx        = PLAY;
                end
                PLAY: begin
                    if (play_done) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign go = (state == LAUNCH);
    assign en = (state == LAUNCH) || (state == PLAY);

`ifdef DROP_COUNT_EN
    // While in LAUNCH, the launching voice is still set in pending, so it is
    // already included in the ones-count. Only a voice in PLAY adds one more.
    // A voice whose play_done arrives together with the tick has finished,
    // so it is not counted as dropped.
    logic [2:0] drops;
    logic [8:0] drop_sum;

    assign drops    = 3'($countones(pending)) +
                      3'((state == PLAY) && !play_done);
    assign drop_sum = {1'b0, drop_cnt} + 9'(drops);

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (run && tick) begin
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end
`endif

endmodule

// File: tb/tb_drum_step_sequencer.sv
// tb_drum_step_sequencer
//   Self-checking bench for drum_step_sequencer. The bench has a behavioural
//   reference model that describes the scheduler in terms of events: which
//   voice the player holds, the cycle of its go pulse, and the hits still
//   waiting. The bench runs the directed scenarios first, then randomized
//   traffic, and compares every output on every cycle.
module tb_drum_step_sequencer;

    localparam int STEPS = 16;
    localparam int DIV_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              run;
    logic [DIV_W-1:0]  tempo_div;
    logic              pat_we;
    logic [1:0]        pat_voice;
    logic [3:0]        pat_step;
    logic              pat_bit;
    logic              play_done;
    logic              go;
    logic              en;
    logic [1:0]        sel;
    logic [3:0]        step;
    logic              tick;
`ifdef DROP_COUNT_EN
    logic [7:0]        drop_cnt;
`endif

    always #5 clk = ~clk;

    drum_step_sequencer #(.STEPS(STEPS), .DIV_W(DIV_W), .MIN_DIV(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .tempo_div (tempo_div),
        .pat_we    (pat_we),
        .pat_voice (pat_voice),
        .pat_step  (pat_step),
        .pat_bit   (pat_bit),
        .play_done (play_done),
        .go        (go),
        .en        (en),
        .sel       (sel),
        .step      (step),
        .tick      (tick)
`ifdef DROP_COUNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    int     n_cmp = 0;
    int     n_bad = 0;
    longint cyc_n = 0;
    int     done_mode = 0;

    // Reference model state.
    bit       m_pat [4][STEPS];
    int       m_step;
    bit       m_was_running;
    int       m_since;      // cycles elapsed since the last tick
    bit [3:0] m_wait;       // hits of the current step not yet handed to the player
    int       m_voice;      // voice the player holds, -1 when free
    longint   m_go_at;      // cycle of that voice's go pulse
    int       m_sel;
    int       m_drop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc_n, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < 4; v++)
            for (int s = 0; s < STEPS; s++) m_pat[v][s] = 1'b0;
        m_step = 0; m_was_running = 1'b0; m_since = 0; m_wait = '0;
        m_voice = -1; m_go_at = -10; m_sel = 0; m_drop = 0;
    endtask

    // One clock cycle: check the outputs at negedge against the model, then
    // advance the model and the DUT.
    task automatic cyc();
        int  eff, ns, v;
        bit  t_e, done_live;
        @(negedge clk);
        eff = (int'(tempo_div) < 3) ? 3 : int'(tempo_div);
        t_e = run && (!m_was_running || m_since == eff + 1);
        chk("tick", tick, t_e);
        chk("go", go, (m_voice >= 0 && cyc_n == m_go_at));
        chk("en", en, (m_voice >= 0));
        chk("sel", sel, m_sel);
        chk("step", step, m_step);
`ifdef DROP_COUNT_EN
        chk("drop_cnt", drop_cnt, m_drop);
`endif
        done_live = (m_voice >= 0) && (cyc_n > m_go_at) && play_done;
        if (!run) begin
            m_voice = -1; m_wait = '0;
        end else if (t_e) begin
            ns = m_was_running ? (m_step + 1) % STEPS : 0;
            m_drop += $countones(m_wait) + ((m_voice >= 0 && !done_live) ? 1 : 0);
            if (m_drop > 255) m_drop = 255;
            m_step = ns;
            for (int k = 0; k < 4; k++) m_wait[k] = m_pat[k][ns];
            m_voice = -1;
            m_since = 1;
        end else begin
            m_since++;
            if (done_live) begin
                m_voice = -1;
            end else if (m_voice < 0 && m_wait != '0) begin
                v = 0;
                while (!m_wait[v]) v++;
                m_wait[v] = 1'b0;
                m_voice = v; m_sel = v; m_go_at = cyc_n + 1;
            end
        end
        m_was_running = run;
        if (pat_we) m_pat[pat_voice][pat_step] = pat_bit;
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic drive_done();
        case (done_mode)
            1: play_done = (m_voice >= 0) && (cyc_n == m_go_at + 5);
            2: play_done = ($urandom_range(3) == 0);
            default: play_done = 1'b0;
        endcase
    endtask

    task automatic run_n(input int n, input bit rnd_wr);
        for (int i = 0; i < n; i++) begin
            drive_done();
            pat_we = rnd_wr ? ($urandom_range(3) == 0) : 1'b0;
            pat_voice = 2'($urandom_range(3));
            pat_step  = 4'($urandom_range(15));
            pat_bit   = 1'($urandom_range(1));
            cyc();
        end
        pat_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; pat_we = 1'b0; play_done = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_go", go, 0);
        chk("rst_en", en, 0);
        chk("rst_sel", sel, 0);
        chk("rst_tick", tick, 0);
        chk("rst_step", step, 0);
        @(posedge clk); #1;
    endtask

    task automatic write_pat(input int v, input int s, input bit b);
        pat_we = 1'b1; pat_voice = 2'(v); pat_step = 4'(s); pat_bit = b;
        play_done = 1'b0;
        cyc();
        pat_we = 1'b0;
    endtask

    initial begin
        int guard;
        reset = 1'b0; run = 1'b0; tempo_div = 16'd9; pat_we = 1'b0;
        pat_voice = '0; pat_step = '0; pat_bit = 1'b0; play_done = 1'b0;
        do_reset();

        // Kick on step 0, kick+hat on step 2, all voices on step 3.
        write_pat(0, 0, 1'b1);
        write_pat(0, 2, 1'b1);
        write_pat(2, 2, 1'b1);
        for (int v = 0; v < 4; v++) write_pat(v, 3, 1'b1);
        tempo_div = 16'd9; run = 1'b1; done_mode = 1;
        run_n(31, 1'b0);              // steps 0..2 with done 5 cycles after go
        done_mode = 0;
        run_n(25, 1'b0);              // step 3 with no done: preemption at step 4

        // Short tempo: values below the minimum act as 3, so the bar wraps.
        run = 1'b0; run_n(2, 1'b0);
        tempo_div = 16'd1; run = 1'b1; done_mode = 2;
        run_n(70, 1'b0);

        // Stop the sequencer while a voice plays, then restart it.
        tempo_div = 16'd9; done_mode = 0;
        guard = 0;
        while (!(m_voice >= 0 && cyc_n > m_go_at) && guard < 200) begin
            run_n(1, 1'b0); guard++;
        end
        chk("wait_play", (guard < 200), 1);
        run = 1'b0; run_n(3, 1'b0);
        run = 1'b1; run_n(12, 1'b0);

        // Write step 5 after it has been captured: the hit plays only on the next pass.
        done_mode = 1;
        guard = 0;
        while (!(m_step == 5 && m_since == 3) && guard < 400) begin
            run_n(1, 1'b0); guard++;
        end
        chk("wait_step5", (guard < 400), 1);
        write_pat(1, 5, 1'b1);
        run_n(170, 1'b0);

        // Reset in the middle of a running bar.
        do_reset();

        // Randomized traffic. Tempo changes only while stopped.
        for (int blk = 0; blk < 30; blk++) begin
            run = 1'b0;
            tempo_div = 16'($urandom_range(12));
            done_mode = 1 + int'($urandom_range(1));
            run_n(2 + int'($urandom_range(3)), 1'b1);
            run = 1'b1;
            run_n(60 + int'($urandom_range(120)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
